// File: rtl/byte_io_arbiter.sv
// byte_io_arbiter: round-robin sharing of a single axi_byte_io byte engine
// between N requesters. One transaction is in flight at a time; the winner
// gets a one-cycle accept pulse, then a one-cycle completion pulse carrying
// the read byte (or 8'h00 for writes).
module byte_io_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_write,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*8-1:0]  req_wdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [7:0]      resp_rdata,
    input  logic            io_busy,
    output logic            io_start,
    output logic            io_write,
    output logic [AW-1:0]   io_addr,
    output logic [7:0]      io_data_write,
    input  logic            io_done,
    input  logic [7:0]      io_data_read
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WAIT
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_ptr_q;
    logic [N-1:0]    req_ready_q;
    logic [N-1:0]    resp_valid_q;
    logic [7:0]      resp_rdata_q;
    logic            io_start_q;
    logic            io_write_q;
    logic [AW-1:0]   io_addr_q;
    logic [7:0]      io_data_write_q;

    logic [GW-1:0]   winner_d;
    logic [GW-1:0]   rr_ptr_d;
    logic [N-1:0]    winner_onehot_d;
    logic [N-1:0]    grant_onehot_d;
    logic            sel_write_d;
    logic [AW-1:0]   sel_addr_d;
    logic [7:0]      sel_wdata_d;

    // Round-robin pick: lowest requesting index at or above rr_ptr, otherwise
    // wrap around to the lowest requesting index overall.
    always_comb begin
        winner_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner_d = GW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (GW'(i) >= rr_ptr_q)) begin
                winner_d = GW'(i);
            end
        end
    end

    // One-hot forms of the candidate winner and the registered grant, plus the
    // pointer value that puts the just-served requester last in line.
    always_comb begin
        winner_onehot_d = '0;
        grant_onehot_d  = '0;
        for (int i = 0; i < N; i++) begin
            winner_onehot_d[i] = (winner_d == GW'(i));
            grant_onehot_d[i]  = (grant_q == GW'(i));
        end
        rr_ptr_d = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
    end

    // Payload slice of the granted requester, latched into the engine outputs.
    always_comb begin
        sel_write_d = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == GW'(i)) begin
                sel_write_d = req_write[i];
                sel_addr_d  = req_addr[i*AW +: AW];
                sel_wdata_d = req_wdata[i*8 +: 8];
            end
        end
    end

    // Arbitration FSM; every output is a register so pulses are glitch-free.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            rr_ptr_q        <= '0;
            req_ready_q     <= '0;
            resp_valid_q    <= '0;
            resp_rdata_q    <= '0;
            io_start_q      <= 1'b0;
            io_write_q      <= 1'b0;
            io_addr_q       <= '0;
            io_data_write_q <= '0;
        end else begin
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            io_start_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((|req_valid) && !io_busy) begin
                        grant_q     <= winner_d;
                        req_ready_q <= winner_onehot_d;
                        state_q     <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    io_write_q      <= sel_write_d;
                    io_addr_q       <= sel_addr_d;
                    io_data_write_q <= sel_wdata_d;
                    io_start_q      <= 1'b1;
                    state_q         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (io_done) begin
                        resp_valid_q <= grant_onehot_d;
                        resp_rdata_q <= io_write_q ? 8'h00 : io_data_read;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign io_start      = io_start_q;
    assign io_write      = io_write_q;
    assign io_addr       = io_addr_q;
    assign io_data_write = io_data_write_q;

endmodule

// File: tb/tb_byte_io_arbiter.sv
// Testbench for byte_io_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level round-robin model.
module tb_byte_io_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;

    logic            aclk;
    logic            aresetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [7:0]      resp_rdata;
    logic            io_busy;
    logic            io_start;
    logic            io_write;
    logic [AW-1:0]   io_addr;
    logic [7:0]      io_data_write;
    logic            io_done;
    logic [7:0]      io_data_read;

    logic [63:0]     allOutputs;

    int checkCount;
    int errorCount;

    // Reference model: which requesters have an outstanding request, their
    // payloads, and the requester that has first claim next round.
    bit              pending   [N];
    bit              pendWrite [N];
    logic [AW-1:0]   pendAddr  [N];
    logic [7:0]      pendData  [N];
    int              mdlPtr;
    bit              randomArrivals;

    byte_io_arbiter #(.N(N), .AW(AW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .io_busy       (io_busy),
        .io_start      (io_start),
        .io_write      (io_write),
        .io_addr       (io_addr),
        .io_data_write (io_data_write),
        .io_done       (io_done),
        .io_data_read  (io_data_read)
    );

    assign allOutputs = {10'b0, req_ready, resp_valid, resp_rdata, io_start,
                         io_write, io_addr, io_data_write};

    // Free-running clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [N-1:0] oneHot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next winner: first pending requester scanning upward from mdlPtr with wrap.
    function automatic int expectedWinner();
        for (int k = 0; k < N; k++) begin
            if (pending[(mdlPtr + k) % N]) begin
                return (mdlPtr + k) % N;
            end
        end
        return -1;
    endfunction

    task automatic raiseRequest(input int r, input bit wr, input logic [AW-1:0] addr,
                                input logic [7:0] data);
        if (!pending[r]) begin
            pending[r]             = 1'b1;
            pendWrite[r]           = wr;
            pendAddr[r]            = addr;
            pendData[r]            = data;
            req_write[r]           = wr;
            req_addr[r*AW +: AW]   = addr;
            req_wdata[r*8 +: 8]    = data;
            req_valid[r]           = 1'b1;
        end
    endtask

    task automatic raiseRandom(input int r);
        raiseRequest(r, 1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom_range(0, 255)));
    endtask

    // Runs one full transaction from IDLE: optional busy window, grant, engine
    // start, engine latency, then completion (or a reset that abandons it).
    task automatic applyStimulus(input int busyCycles, input int latency,
                                 input logic [7:0] rdata, input bit abort);
        int win;
        int lat;
        lat = latency;
        if (busyCycles > 0) begin
            io_busy = 1'b1;
            repeat (busyCycles) begin
                @(negedge aclk);
                checkOutput("busyNoReady", req_ready, '0);
                checkOutput("busyNoStart", io_start, 0);
            end
            io_busy = 1'b0;
        end
        win = expectedWinner();
        @(negedge aclk);
        checkOutput("grantReady", req_ready, oneHot(win));
        checkOutput("grantNoStart", io_start, 0);
        @(negedge aclk);
        checkOutput("readyPulse", req_ready, '0);
        checkOutput("ioStart", io_start, 1);
        checkOutput("ioWrite", io_write, pendWrite[win]);
        checkOutput("ioAddr", io_addr, pendAddr[win]);
        checkOutput("ioWdata", io_data_write, pendData[win]);
        req_valid[win] = 1'b0;
        if (abort && lat == 0) begin
            lat = 1;
        end
        for (int c = 0; c < lat; c++) begin
            if (randomArrivals && $urandom_range(0, 2) == 0) begin
                raiseRandom(int'($urandom_range(0, N - 1)));
            end
            @(negedge aclk);
            checkOutput("waitNoResp", resp_valid, '0);
            checkOutput("waitNoStart", io_start, 0);
            checkOutput("waitNoReady", req_ready, '0);
            if (abort) begin
                aresetn = 1'b0;
                @(negedge aclk);
                checkOutput("abortOutputs", allOutputs, 0);
                aresetn = 1'b1;
                pending[win] = 1'b0;
                mdlPtr = 0;
                return;
            end
        end
        io_done      = 1'b1;
        io_data_read = rdata;
        @(negedge aclk);
        io_done      = 1'b0;
        io_data_read = 8'($urandom_range(0, 255));
        checkOutput("respValid", resp_valid, oneHot(win));
        checkOutput("respRdata", resp_rdata, pendWrite[win] ? 8'h00 : rdata);
        checkOutput("respNoStart", io_start, 0);
        checkOutput("addrHeld", io_addr, pendAddr[win]);
        pending[win] = 1'b0;
        mdlPtr = (win + 1) % N;
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        checkCount     = 0;
        errorCount     = 0;
        aresetn        = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_addr       = '0;
        req_wdata      = '0;
        io_busy        = 1'b0;
        io_done        = 1'b0;
        io_data_read   = '0;
        mdlPtr         = 0;
        randomArrivals = 1'b0;
        for (int r = 0; r < N; r++) begin
            pending[r]   = 1'b0;
            pendWrite[r] = 1'b0;
            pendAddr[r]  = '0;
            pendData[r]  = '0;
        end

        repeat (3) @(negedge aclk);
        checkOutput("resetOutputs", allOutputs, 0);
        aresetn = 1'b1;

        $display("[TB] single read");
        raiseRequest(0, 1'b0, 32'h0000_1000, 8'h00);
        applyStimulus(0, 5, 8'hA5, 1'b0);

        $display("[TB] single write");
        raiseRequest(1, 1'b1, 32'h0000_2004, 8'h3C);
        applyStimulus(0, 3, 8'h77, 1'b0);

        $display("[TB] round robin with both requesters busy");
        repeat (4) begin
            for (int r = 0; r < N; r++) begin
                raiseRandom(r);
            end
            applyStimulus(0, int'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 1'b0);
        end

        $display("[TB] engine busy window");
        for (int r = 0; r < N; r++) begin
            raiseRandom(r);
        end
        applyStimulus(10, 2, 8'h5E, 1'b0);

        $display("[TB] reset while waiting on the engine");
        raiseRandom(1);
        applyStimulus(0, 3, 8'h00, 1'b1);
        for (int r = 0; r < N; r++) begin
            raiseRandom(r);
        end
        applyStimulus(0, 2, 8'hC3, 1'b0);

        $display("[TB] zero-latency completion");
        raiseRequest(1, 1'b0, 32'h0000_3000, 8'h00);
        applyStimulus(0, 0, 8'h5A, 1'b0);
        raiseRequest(0, 1'b0, 32'h0000_3001, 8'h00);
        applyStimulus(0, 0, 8'h96, 1'b0);

        $display("[TB] stray completion while idle");
        io_done      = 1'b1;
        io_data_read = 8'hEE;
        @(negedge aclk);
        io_done = 1'b0;
        checkOutput("strayNoResp", resp_valid, '0);
        checkOutput("strayNoRdata", resp_rdata, 0);
        checkOutput("strayNoReady", req_ready, '0);

        $display("[TB] randomized traffic");
        randomArrivals = 1'b1;
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    raiseRandom(r);
                end
            end
            if (expectedWinner() < 0) begin
                raiseRandom(int'($urandom_range(0, N - 1)));
            end
            applyStimulus(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                          int'($urandom_range(0, 6)),
                          8'($urandom_range(0, 255)),
                          ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
